// File: rtl/alu_pipe_seg.sv
// Segmented-carry pipelined ALU for the Y86-64 execute stage.
// Each stage handles one SEG-bit slice of add/sub/and/xor. The last stage registers result and ZF/SF/OF.
module alu_pipe_seg #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   localparam int SEG = WIDTH / STAGES;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   logic advance;

   // Global stall: the whole pipe moves only when the output slot is free or being drained.
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int AW = WIDTH - k * SEG;
      localparam int CW = (k < STAGES - 1) ? SEG + 1 : SEG;

      logic                 vi;
      logic                 cyi;
      logic                 zi;
      logic                 zn;
      logic [1:0]           opi;
      logic [AW-1:0]        ai;
      logic [AW-1:0]        bxi;
      logic [CW-1:0]        sum;
      logic [SEG-1:0]       seg;
      logic [(k+1)*SEG-1:0] resn;

      if (k == 0) begin : g_in
         // Sub is a + ~b + 1, so b is inverted on entry and the first carry-in is 1.
         assign vi   = in_valid;
         assign opi  = op;
         assign ai   = a;
         assign bxi  = (op == OP_SUB) ? ~b : b;
         assign cyi  = (op == OP_SUB);
         assign zi   = 1'b1;
         assign resn = seg;
      end else begin : g_link
         assign vi   = g_stage[k-1].g_mid.v_q;
         assign opi  = g_stage[k-1].g_mid.op_q;
         assign ai   = g_stage[k-1].g_mid.a_q;
         assign bxi  = g_stage[k-1].g_mid.bx_q;
         assign cyi  = g_stage[k-1].g_mid.cy_q;
         assign zi   = g_stage[k-1].g_mid.z_q;
         assign resn = {seg, g_stage[k-1].g_mid.res_q};
      end

      assign sum = CW'(ai[SEG-1:0]) + CW'(bxi[SEG-1:0]) + CW'(cyi);

      always_comb begin
         seg = sum[SEG-1:0];
         case (opi)
            OP_AND:  seg = ai[SEG-1:0] & bxi[SEG-1:0];
            OP_XOR:  seg = ai[SEG-1:0] ^ bxi[SEG-1:0];
            default: ;
         endcase
      end

      assign zn = zi & (seg == '0);

      if (k < STAGES - 1) begin : g_mid
         // Consumed operand slices are dropped. Only the unprocessed upper part travels on.
         logic                 v_q;
         logic                 cy_q;
         logic                 z_q;
         logic [1:0]           op_q;
         logic [AW-SEG-1:0]    a_q;
         logic [AW-SEG-1:0]    bx_q;
         logic [(k+1)*SEG-1:0] res_q;

         always_ff @(posedge clk or posedge rst) begin
            // NOTE: data registers are reset along with the valids so result/flags read 0 out of reset.
            if (rst) begin
               v_q   <= 1'b0;
               cy_q  <= 1'b0;
               z_q   <= 1'b0;
               op_q  <= '0;
               a_q   <= '0;
               bx_q  <= '0;
               res_q <= '0;
            end else if (advance) begin
               v_q   <= vi;
               cy_q  <= sum[SEG];
               z_q   <= zn;
               op_q  <= opi;
               a_q   <= ai[AW-1:SEG];
               bx_q  <= bxi[AW-1:SEG];
               res_q <= resn;
            end
         end
      end else begin : g_last
         logic             v_q;
         logic             z_q;
         logic             of_q;
         logic [WIDTH-1:0] res_q;

         // With b already inverted for sub, add and sub share one overflow rule.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v_q   <= 1'b0;
               z_q   <= 1'b0;
               of_q  <= 1'b0;
               res_q <= '0;
            end else if (advance) begin
               v_q   <= vi;
               z_q   <= zn;
               of_q  <= ~opi[1] & (ai[SEG-1] == bxi[SEG-1]) & (seg[SEG-1] != ai[SEG-1]);
               res_q <= resn;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].g_last.v_q;
   assign result    = g_stage[STAGES-1].g_last.res_q;
   assign zf        = g_stage[STAGES-1].g_last.z_q;
   assign sf        = g_stage[STAGES-1].g_last.res_q[WIDTH-1];
   assign of        = g_stage[STAGES-1].g_last.of_q;

endmodule
